// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the 8N1 UART transmitter and receiver.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 32;
  localparam int BIT_IDX_W            = 3;
  localparam int DATA_W               = 8;

  localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = BIT_IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchroniser, mid-bit sampling FSM, stop-bit framing check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              clk32,
  input  logic              reset_,
  input  logic              rx,
  output logic [DATA_W-1:0] rxdata,
  output logic              rx_enable
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic                 r_rx_meta;
  logic                 r_rx_sync;
  rx_state_t            r_rx_state;
  logic [CNT_W-1:0]     r_rx_cnt;
  logic [BIT_IDX_W-1:0] r_rx_bit_idx;
  logic [DATA_W-1:0]    r_rx_shift;
  logic [DATA_W-1:0]    r_rxdata;
  logic                 r_rx_enable;

  rx_state_t            w_rx_state_next;
  logic [CNT_W-1:0]     w_rx_cnt_next;
  logic [BIT_IDX_W-1:0] w_rx_bit_idx_next;
  logic [DATA_W-1:0]    w_rx_shift_next;
  logic [DATA_W-1:0]    w_rxdata_next;
  logic                 w_rx_enable_next;
  logic                 w_bit_end;

  assign w_bit_end = (r_rx_cnt == CNT_LAST);

  // Synchroniser flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk32) begin
    if (!reset_) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit_idx <= '0;
      r_rx_shift   <= '0;
      r_rxdata     <= '0;
      r_rx_enable  <= 1'b0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_sync    <= r_rx_meta;
      r_rx_state   <= w_rx_state_next;
      r_rx_cnt     <= w_rx_cnt_next;
      r_rx_bit_idx <= w_rx_bit_idx_next;
      r_rx_shift   <= w_rx_shift_next;
      r_rxdata     <= w_rxdata_next;
      r_rx_enable  <= w_rx_enable_next;
    end
  end

  always_comb begin
    w_rx_state_next   = r_rx_state;
    w_rx_cnt_next     = r_rx_cnt;
    w_rx_bit_idx_next = r_rx_bit_idx;
    w_rx_shift_next   = r_rx_shift;
    w_rxdata_next     = r_rxdata;
    w_rx_enable_next  = 1'b0;

    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_next = '0;
        if (!r_rx_sync) begin
          w_rx_state_next = RX_START;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_next     = '0;
          w_rx_bit_idx_next = '0;
          w_rx_state_next   = r_rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_next = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (w_bit_end) begin
          w_rx_cnt_next   = '0;
          w_rx_shift_next = {r_rx_sync, r_rx_shift[DATA_W-1:1]};
          if (r_rx_bit_idx == LAST_BIT_IDX) begin
            w_rx_state_next = RX_STOP;
          end else begin
            w_rx_bit_idx_next = r_rx_bit_idx + 1'b1;
          end
        end else begin
          w_rx_cnt_next = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (w_bit_end) begin
          // Leaving at mid-stop lets the next start edge be caught without delay.
          w_rx_cnt_next   = '0;
          w_rx_state_next = RX_IDLE;
          if (r_rx_sync) begin
            w_rxdata_next    = r_rx_shift;
            w_rx_enable_next = 1'b1;
          end
        end else begin
          w_rx_cnt_next = r_rx_cnt + 1'b1;
        end
      end
      default: begin
        w_rx_state_next = RX_IDLE;
        w_rx_cnt_next   = '0;
      end
    endcase
  end

  assign rxdata    = r_rxdata;
  assign rx_enable = r_rx_enable;

endmodule

// File: rtl/uart_8n1.sv
// Full-duplex 8N1 UART: transmitter with one-entry holding register, plus the uart_rx receiver.
module uart_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              clk32,
  input  logic              reset_,
  input  logic              tx_enable,
  input  logic [DATA_W-1:0] txdata,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] rxdata,
  output logic              rx_enable
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t            r_tx_state;
  logic [CNT_W-1:0]     r_tx_cnt;
  logic [BIT_IDX_W-1:0] r_tx_bit_idx;
  logic [DATA_W-1:0]    r_tx_shift;
  logic                 r_tx;
  logic [DATA_W-1:0]    r_hold_data;
  logic                 r_hold_full;

  tx_state_t            w_tx_state_next;
  logic [CNT_W-1:0]     w_tx_cnt_next;
  logic [BIT_IDX_W-1:0] w_tx_bit_idx_next;
  logic [DATA_W-1:0]    w_tx_shift_next;
  logic                 w_tx_next;
  logic [DATA_W-1:0]    w_hold_data_next;
  logic                 w_hold_full_next;
  logic                 w_tx_load;
  logic                 w_bit_end;

  assign w_bit_end = (r_tx_cnt == CNT_LAST);

  always_ff @(posedge clk32) begin
    if (!reset_) begin
      r_tx_state   <= TX_IDLE;
      r_tx_cnt     <= '0;
      r_tx_bit_idx <= '0;
      r_tx_shift   <= '0;
      r_tx         <= 1'b1;
      r_hold_data  <= '0;
      r_hold_full  <= 1'b0;
    end else begin
      r_tx_state   <= w_tx_state_next;
      r_tx_cnt     <= w_tx_cnt_next;
      r_tx_bit_idx <= w_tx_bit_idx_next;
      r_tx_shift   <= w_tx_shift_next;
      r_tx         <= w_tx_next;
      r_hold_data  <= w_hold_data_next;
      r_hold_full  <= w_hold_full_next;
    end
  end

  // r_tx is registered from the next-state decode, so the pin changes exactly on bit boundaries.
  always_comb begin
    w_tx_state_next   = r_tx_state;
    w_tx_cnt_next     = r_tx_cnt;
    w_tx_bit_idx_next = r_tx_bit_idx;
    w_tx_shift_next   = r_tx_shift;
    w_tx_next         = r_tx;
    w_hold_data_next  = r_hold_data;
    w_hold_full_next  = r_hold_full;
    w_tx_load         = 1'b0;

    // Capture and load are exclusive: capture needs an empty holding register, load a full one.
    if (tx_enable && !r_hold_full) begin
      w_hold_full_next = 1'b1;
      w_hold_data_next = txdata;
    end

    case (r_tx_state)
      TX_IDLE: begin
        w_tx_next = 1'b1;
        w_tx_load = r_hold_full;
      end
      TX_START: begin
        if (w_bit_end) begin
          w_tx_cnt_next     = '0;
          w_tx_bit_idx_next = '0;
          w_tx_state_next   = TX_DATA;
          w_tx_next         = r_tx_shift[0];
        end else begin
          w_tx_cnt_next = r_tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (w_bit_end) begin
          w_tx_cnt_next = '0;
          if (r_tx_bit_idx == LAST_BIT_IDX) begin
            w_tx_state_next = TX_STOP;
            w_tx_next       = 1'b1;
          end else begin
            w_tx_bit_idx_next = r_tx_bit_idx + 1'b1;
            w_tx_shift_next   = {1'b0, r_tx_shift[DATA_W-1:1]};
            w_tx_next         = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_next = r_tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (w_bit_end) begin
          w_tx_cnt_next = '0;
          if (r_hold_full) begin
            w_tx_load = 1'b1;
          end else begin
            w_tx_state_next = TX_IDLE;
            w_tx_next       = 1'b1;
          end
        end else begin
          w_tx_cnt_next = r_tx_cnt + 1'b1;
        end
      end
      default: begin
        w_tx_state_next = TX_IDLE;
        w_tx_cnt_next   = '0;
        w_tx_next       = 1'b1;
      end
    endcase

    // Loading from the holding register starts the start bit in the same transition.
    if (w_tx_load) begin
      w_tx_state_next   = TX_START;
      w_tx_shift_next   = r_hold_data;
      w_hold_full_next  = 1'b0;
      w_tx_cnt_next     = '0;
      w_tx_bit_idx_next = '0;
      w_tx_next         = 1'b0;
    end
  end

  assign tx = r_tx;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk32    (clk32),
    .reset_   (reset_),
    .rx       (rx),
    .rxdata   (rxdata),
    .rx_enable(rx_enable)
  );

endmodule

// File: tb/tb_uart_8n1.sv
// Scoreboard bench for uart_8n1: loopback sweep, frame shape, holding register, RX errors, reset mid-frame.
module tb_uart_8n1;

  localparam int CPB = 16;

  logic       clk32;
  logic       reset_;
  logic       tx_enable;
  logic [7:0] txdata;
  logic       tx;
  logic       rx_line;
  logic [7:0] rxdata;
  logic       rx_enable;

  logic       rx_sel;
  logic       rx_drv;

  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_errors;
  int         strobe_cnt;
  int         cyc;
  int         strobe_prev_cyc;
  int         strobe_last_cyc;
  logic       prev_en;

  assign rx_line = rx_sel ? tx : rx_drv;

  uart_8n1 #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk32    (clk32),
    .reset_   (reset_),
    .tx_enable(tx_enable),
    .txdata   (txdata),
    .tx       (tx),
    .rx       (rx_line),
    .rxdata   (rxdata),
    .rx_enable(rx_enable)
  );

  initial begin
    clk32 = 1'b0;
    forever #5 clk32 = ~clk32;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receive-side monitor: pops the scoreboard on every strobe.
  initial begin
    cyc             = 0;
    strobe_cnt      = 0;
    strobe_prev_cyc = 0;
    strobe_last_cyc = 0;
    prev_en         = 1'b0;
    forever begin
      @(negedge clk32);
      cyc++;
      if (rx_enable === 1'b1) begin
        check("rx_enable_single_cycle", {31'b0, prev_en}, 32'd0);
        if (exp_q.size() == 0) begin
          check("rx_strobe_expected", {24'b0, rxdata}, 32'h100);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("rxdata", {24'b0, rxdata}, {24'b0, e});
          $display("rx byte 0x%02h (expected 0x%02h) at cycle %0d", rxdata, e, cyc);
        end
        strobe_cnt++;
        strobe_prev_cyc = strobe_last_cyc;
        strobe_last_cyc = cyc;
      end
      prev_en = (rx_enable === 1'b1);
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk32);
    tx_enable = 1'b1;
    txdata    = b;
    @(negedge clk32);
    tx_enable = 1'b0;
  endtask

  task automatic wait_q_empty(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk32);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  task automatic wait_tx_low(input int limit);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < limit) begin
      @(negedge clk32);
      n++;
    end
    check("tx_start_seen", {31'b0, tx}, 32'd0);
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat (CPB) @(negedge clk32);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [9:0] frame;
    int         base_cnt;

    n_checks  = 0;
    n_errors  = 0;
    reset_    = 1'b0;
    tx_enable = 1'b0;
    txdata    = 8'h00;
    rx_sel    = 1'b1;
    rx_drv    = 1'b1;

    // Reset state
    repeat (3) @(posedge clk32);
    @(negedge clk32);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_rxdata", {24'b0, rxdata}, 32'h00);
    check("reset_rx_enable", {31'b0, rx_enable}, 32'd0);
    reset_ = 1'b1;
    repeat (4) @(negedge clk32);

    // Frame shape of 0xA5, sampled mid-bit
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    wait_tx_low(8);
    frame = {1'b1, 8'hA5, 1'b0};
    repeat (CPB / 2) @(negedge clk32);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("frame_bit%0d", i), {31'b0, tx}, {31'b0, frame[i]});
      $display("frame bit %0d: tx=%b expected %b", i, tx, frame[i]);
      if (i < 9) repeat (CPB) @(negedge clk32);
    end
    wait_q_empty(12 * CPB);

    // Loopback sweep 0x00..0xFF, next byte sent right after each strobe
    for (int b = 0; b < 256; b++) begin
      exp_q.push_back(8'(b));
      send_byte(8'(b));
      wait_q_empty(14 * CPB);
    end
    check("sweep_final_rxdata", {24'b0, rxdata}, 32'hFF);

    // Holding register: 0x3C, 0xC3 mid-frame, 0x11 dropped
    repeat (2 * CPB) @(negedge clk32);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_byte(8'h3C);
    wait_tx_low(8);
    repeat (3 * CPB) @(negedge clk32);
    send_byte(8'hC3);
    repeat (5) @(negedge clk32);
    send_byte(8'h11);
    wait_q_empty(30 * CPB);
    check("back_to_back_spacing", strobe_last_cyc - strobe_prev_cyc, 10 * CPB);
    base_cnt = strobe_cnt;
    repeat (12 * CPB) @(negedge clk32);
    check("dropped_byte_absent", strobe_cnt, base_cnt);

    // RX errors: short glitch, then framing error
    rx_sel = 1'b0;
    rx_drv = 1'b1;
    repeat (4) @(negedge clk32);
    base_cnt = strobe_cnt;
    rx_drv = 1'b0;
    repeat (4) @(negedge clk32);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk32);
    check("glitch_no_strobe", strobe_cnt, base_cnt);
    drive_rx_frame(8'h5A, 1'b0);
    repeat (12 * CPB) @(negedge clk32);
    check("framing_err_no_strobe", strobe_cnt, base_cnt);
    check("framing_err_rxdata_held", {24'b0, rxdata}, 32'hC3);
    exp_q.push_back(8'hE7);
    drive_rx_frame(8'hE7, 1'b1);
    wait_q_empty(4 * CPB);
    rx_sel = 1'b1;
    repeat (2 * CPB) @(negedge clk32);

    // Reset during data bit 4 of a transmitted frame
    base_cnt = strobe_cnt;
    send_byte(8'h77);
    wait_tx_low(8);
    repeat (5 * CPB + CPB / 2) @(negedge clk32);
    reset_ = 1'b0;
    @(negedge clk32);
    check("midframe_reset_tx", {31'b0, tx}, 32'd1);
    check("midframe_reset_rxdata", {24'b0, rxdata}, 32'h00);
    reset_ = 1'b1;
    repeat (12 * CPB) @(negedge clk32);
    check("partial_frame_no_strobe", strobe_cnt, base_cnt);
    exp_q.push_back(8'h96);
    send_byte(8'h96);
    wait_q_empty(14 * CPB);
    check("post_reset_rxdata", {24'b0, rxdata}, 32'h96);

    repeat (4) @(negedge clk32);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
